// File: rtl/reset_cond_pkg.sv
// reset_cond_pkg: shared watchdog state codes and status-word bit positions
// for trigger_watchdog_conditioner.
package reset_cond_pkg;
    typedef enum logic [1:0] {
        WD_DISARMED = 2'b00,
        WD_ARMING   = 2'b01,
        WD_RUNNING  = 2'b10,
        WD_EXPIRED  = 2'b11
    } wd_state_t;

    localparam int STS_TRIG  = 0;
    localparam int STS_WD    = 1;
    localparam int STS_IRST  = 2;
    localparam int STS_EXP   = 3;
    localparam int STS_OK    = 4;
    localparam int STS_STATE = 5;
    localparam int STS_EDGES = 16;
endpackage

// File: rtl/glitch_filter.sv
// glitch_filter: 2FF synchroniser, stability-counter glitch filter and registered edge pulses.
// Ports: clk_i, rst_i (async, active high), raw_i (async pin),
//        clean_o (filtered level), rise_o/fall_o (1-cycle registered pulses),
//        edge_o (strobe, high in the cycle before clean_o changes).
module glitch_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_o
);
    logic       s0_q, s1_q, c_q, rise_q, fall_q, hit;
    logic [7:0] cnt_q, cnt_d;

    // Last differing sample of a full stable run: the clean level flips on this edge.
    assign hit   = (s1_q != c_q) && (cnt_q == 8'(FILTER_CYCLES - 1));
    assign cnt_d = (s1_q == c_q || hit) ? 8'd0 : cnt_q + 8'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            c_q    <= 1'b0;
            cnt_q  <= 8'd0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s0_q   <= raw_i;
            s1_q   <= s0_q;
            c_q    <= c_q ^ hit;
            cnt_q  <= cnt_d;
            rise_q <= hit & s1_q;
            fall_q <= hit & ~s1_q;
        end
    end

    assign clean_o = c_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign edge_o  = hit;
endmodule

// File: rtl/trigger_watchdog_conditioner.sv
// trigger_watchdog_conditioner: conditions trigger/watchdog/instant_reset pins and supervises the watchdog.
// Ports: clk, peripheral_areset (async, active high); *_raw pins; watchdog_enable, timeout_clear (cfg);
//        clean levels and trigger edge pulses; watchdog_ok/state/edges verdict; cond_sts status word.
module trigger_watchdog_conditioner
    import reset_cond_pkg::*;
#(
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 12500000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             peripheral_areset,
    input  logic             trigger_raw,
    input  logic             watchdog_raw,
    input  logic             instant_reset_raw,
    input  logic             watchdog_enable,
    input  logic             timeout_clear,
    output logic             trigger_clean,
    output logic             trigger_rise,
    output logic             trigger_fall,
    output logic             instant_reset_clean,
    output logic             watchdog_clean,
    output logic             watchdog_ok,
    output logic [1:0]       watchdog_state,
    output logic [CNT_W-1:0] watchdog_edges,
    output logic [31:0]      cond_sts
);
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic rst_meta_q, rst_q;
    logic trig_edge, wd_edge, wd_rise, wd_fall, irst_rise, irst_fall, irst_edge;
    logic unused;
    wd_state_t state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [CNT_W-1:0] edges_q;
    logic ok_q;
    logic [CNT_W+15:0] edges_ext;

    // Reset asserts at once, releases two clk edges later.
    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) {rst_meta_q, rst_q} <= 2'b11;
        else                   {rst_meta_q, rst_q} <= {1'b0, rst_meta_q};
    end

    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_trig (
        .clk_i(clk), .rst_i(rst_q), .raw_i(trigger_raw),
        .clean_o(trigger_clean), .rise_o(trigger_rise), .fall_o(trigger_fall), .edge_o(trig_edge)
    );
    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_wd (
        .clk_i(clk), .rst_i(rst_q), .raw_i(watchdog_raw),
        .clean_o(watchdog_clean), .rise_o(wd_rise), .fall_o(wd_fall), .edge_o(wd_edge)
    );
    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_irst (
        .clk_i(clk), .rst_i(rst_q), .raw_i(instant_reset_raw),
        .clean_o(instant_reset_clean), .rise_o(irst_rise), .fall_o(irst_fall), .edge_o(irst_edge)
    );
    assign unused = ^{trig_edge, wd_rise, wd_fall, irst_rise, irst_fall, irst_edge};

    // wd_edge is the strobe that flips watchdog_clean, so the FSM and edge counter
    // act on the same edge at which the clean level changes.
    always_comb begin
        state_d  = state_q;
        wd_cnt_d = wd_cnt_q;
        if (!watchdog_enable) begin
            state_d  = WD_DISARMED;
            wd_cnt_d = '0;
        end else begin
            case (state_q)
                WD_DISARMED: state_d = WD_ARMING;
                WD_ARMING: if (wd_edge) begin
                    state_d  = WD_RUNNING;
                    wd_cnt_d = '0;
                end
                WD_RUNNING: begin
                    if (wd_edge)                  wd_cnt_d = '0;
                    else if (wd_cnt_q == WD_LAST) state_d  = WD_EXPIRED;
                    else                          wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
                WD_EXPIRED: if (timeout_clear) state_d = WD_ARMING;
                default: state_d = WD_DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_q) begin
        if (rst_q) begin
            state_q  <= WD_DISARMED;
            wd_cnt_q <= '0;
            edges_q  <= '0;
            ok_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
            edges_q  <= edges_q + CNT_W'(wd_edge);
            ok_q     <= (state_d != WD_EXPIRED);
        end
    end

    assign edges_ext = {16'd0, edges_q};

    always_comb begin
        cond_sts                      = '0;
        cond_sts[STS_TRIG]            = trigger_clean;
        cond_sts[STS_WD]              = watchdog_clean;
        cond_sts[STS_IRST]            = instant_reset_clean;
        cond_sts[STS_EXP]             = ~ok_q;
        cond_sts[STS_OK]              = ok_q;
        cond_sts[STS_STATE +: 2]      = state_q;
        cond_sts[STS_EDGES +: 16]     = edges_ext[15:0];
    end

    assign watchdog_ok    = ok_q;
    assign watchdog_state = state_q;
    assign watchdog_edges = edges_q;
endmodule
